// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles every handshake and data signal between the fetch unit and its
//   neighbours. The fetch unit connects through the master modport. The
//   environment (predictor, instruction memory, decode) connects through the
//   slave modport.
//
//   Signal summary (direction as seen by the master):
//     redirect_valid/redirect_pc   in   squash and restart fetch
//     bp_pc                        out  current fetch PC, sent to the predictor
//     bp_taken/bp_target           in   combinational prediction for bp_pc
//     imem_req_valid/ready/addr    out/in/out  instruction-memory request
//     imem_rsp_valid/data/fault    in   in-order memory response
//     dec_valid/ready              out/in  fetch-queue head handshake
//     dec_instr/pc/pred_taken/pred_pc/trap_cause  out  fetch-queue head payload
//     fq_count                     out  fetch-queue occupancy
interface fetch_unit_if #(
  parameter int PC_W     = 48,
  parameter int FQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;

  logic [PC_W-1:0]  bp_pc;
  logic             bp_taken;
  logic [PC_W-1:0]  bp_target;

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [PC_W-1:0]  imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             imem_rsp_fault;

  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_instr;
  logic [PC_W-1:0]  dec_pc;
  logic             dec_pred_taken;
  logic [PC_W-1:0]  dec_pred_pc;
  logic [1:0]       dec_trap_cause;
  logic [CNT_W-1:0] fq_count;

  modport master (
    input  redirect_valid, redirect_pc, bp_taken, bp_target,
           imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_fault,
           dec_ready,
    output bp_pc, imem_req_valid, imem_req_addr,
           dec_valid, dec_instr, dec_pc, dec_pred_taken, dec_pred_pc,
           dec_trap_cause, fq_count
  );

  modport slave (
    output redirect_valid, redirect_pc, bp_taken, bp_target,
           imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_fault,
           dec_ready,
    input  bp_pc, imem_req_valid, imem_req_addr,
           dec_valid, dec_instr, dec_pc, dec_pred_taken, dec_pred_pc,
           dec_trap_cause, fq_count
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch front end. Walks the PC stream under predictor
//   control, keeps up to MAX_OUTST requests in flight to instruction memory
//   (any in-order latency of at least one cycle), and buffers responses in a
//   FQ_DEPTH-entry fetch queue ahead of decode. Queue space is reserved at
//   request time, so memory responses never need back-pressure. A redirect
//   squashes the queue and everything in flight. Misaligned PCs and access
//   faults become trap entries in program order, after which fetch halts
//   until the next redirect.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    fetch_unit_if.master (predictor, imem and decode signals)
module fetch_unit #(
  parameter int              PC_W      = 48,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int TPW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_FAULT    = 2'd2;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  // One entry per accepted-but-unanswered request.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] next;
    logic            kill;
  } tag_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_pc;
    logic [1:0]      cause;
  } fq_t;

  state_e           state;
  logic [PC_W-1:0]  fetch_pc;
  logic [OUT_W-1:0] outst;

  tag_t             tag_q [MAX_OUTST];
  logic [TPW-1:0]   tag_wr, tag_rd;

  // Shift-register queue: entry 0 is always the head, so the decode outputs
  // come straight from flops.
  fq_t              fq_q [FQ_DEPTH];
  fq_t              fq_n [FQ_DEPTH];
  logic [CNT_W-1:0] fq_cnt, fq_cnt_n;

  logic             redir;
  logic             aligned, credit_ok, req_valid, req_fire;
  logic             rsp_take, rsp_enq, mis_enq, enq, deq, dec_valid;
  logic [PC_W-1:0]  next_pc;
  tag_t             rsp_tag;
  fq_t              enq_ent;

  function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OUTST - 1)) ? '0 : p + TPW'(1);
  endfunction

  assign redir     = bus.redirect_valid;
  assign aligned   = (fetch_pc[1:0] == 2'b00);
  // Every accepted request owns a future queue slot.
  assign credit_ok = (int'(fq_cnt) + int'(outst)) < FQ_DEPTH;
  assign req_valid = !reset && (state == ST_RUN) && aligned &&
                     (int'(outst) < MAX_OUTST) && credit_ok && !redir;
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign next_pc   = bus.bp_taken ? bus.bp_target : fetch_pc + PC_W'(4);

  // A response with nothing outstanding is a stale post-reset reply; ignore
  // it so outst can never underflow.
  assign rsp_take  = bus.imem_rsp_valid && (outst != '0);
  assign rsp_enq   = rsp_take && !rsp_tag.kill && (state == ST_RUN) && !redir;
  // The misaligned trap waits for older in-flight work to drain so it lands
  // in program order.
  assign mis_enq   = (state == ST_RUN) && !aligned && (outst == '0) &&
                     (fq_cnt != CNT_W'(FQ_DEPTH)) && !redir;
  assign enq       = rsp_enq || mis_enq;

  assign dec_valid = !reset && (fq_cnt != '0);
  assign deq       = dec_valid && bus.dec_ready;

  // NOTE: combinational blocks assign every target a default first and use
  // blocking assignments, so no latch is inferred and later lines see the
  // updated values.
  always_comb begin
    rsp_tag = tag_q[0];
    for (int i = 1; i < MAX_OUTST; i++) begin
      if (tag_rd == TPW'(i)) rsp_tag = tag_q[i];
    end
  end

  always_comb begin
    enq_ent = '0;
    if (mis_enq) begin
      enq_ent.pc    = fetch_pc;
      enq_ent.cause = CAUSE_MISALIGN;
    end else begin
      enq_ent.instr      = bus.imem_rsp_data;
      enq_ent.pc         = rsp_tag.pc;
      enq_ent.pred_taken = rsp_tag.taken;
      enq_ent.pred_pc    = rsp_tag.next;
      enq_ent.cause      = bus.imem_rsp_fault ? CAUSE_FAULT : CAUSE_NONE;
    end
  end

  always_comb begin
    fq_n     = fq_q;
    fq_cnt_n = fq_cnt;
    if (deq) begin
      for (int i = 0; i < FQ_DEPTH - 1; i++) fq_n[i] = fq_q[i + 1];
      fq_cnt_n = fq_cnt - CNT_W'(1);
    end
    if (enq) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        if (fq_cnt_n == CNT_W'(i)) fq_n[i] = enq_ent;
      end
      fq_cnt_n = fq_cnt_n + CNT_W'(1);
    end
    // Redirect beats a same-cycle dequeue or enqueue: the queue ends empty.
    if (redir) fq_cnt_n = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      fetch_pc <= START_PC;
      outst    <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      fq_cnt   <= '0;
    end else begin
      fq_cnt <= fq_cnt_n;
      if (req_fire) tag_wr <= tag_inc(tag_wr);
      if (rsp_take) tag_rd <= tag_inc(tag_rd);
      if (req_fire && !rsp_take)      outst <= outst + OUT_W'(1);
      else if (!req_fire && rsp_take) outst <= outst - OUT_W'(1);

      if (redir) begin
        fetch_pc <= bus.redirect_pc;
        state    <= ST_RUN;
      end else begin
        if (req_fire) fetch_pc <= next_pc;
        if (mis_enq || (rsp_enq && bus.imem_rsp_fault)) state <= ST_HALT;
      end
    end
  end

  // NOTE: the tag and queue storage is deliberately not reset; the pointers
  // and counters above decide which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (redir) begin
        tag_q[i].kill <= 1'b1;
      end else if (req_fire && (tag_wr == TPW'(i))) begin
        tag_q[i] <= '{pc: fetch_pc, taken: bus.bp_taken, next: next_pc, kill: 1'b0};
      end
    end
    fq_q <= fq_n;
  end

  assign bus.bp_pc          = fetch_pc;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_instr      = fq_q[0].instr;
  assign bus.dec_pc         = fq_q[0].pc;
  assign bus.dec_pred_taken = fq_q[0].pred_taken;
  assign bus.dec_pred_pc    = fq_q[0].pred_pc;
  assign bus.dec_trap_cause = fq_q[0].cause;
  assign bus.fq_count       = reset ? '0 : fq_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A transaction-level reference model
//   (queues of in-flight requests and of expected decode entries) predicts
//   the request handshake, the fetch PC and the decode head every cycle.
//   Directed phases reproduce the documented scenarios, followed by a long
//   randomized phase with random latency, back-pressure, predictions,
//   faults, redirects and one mid-run reset.
module tb_fetch_unit;
  localparam int              PC_W      = 48;
  localparam int              FQ_DEPTH  = 4;
  localparam int              MAX_OUTST = 2;
  localparam logic [PC_W-1:0] START_PC  = 48'h1000;
  localparam logic [PC_W-1:0] NO_PC     = '1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(PC_W), .FQ_DEPTH(FQ_DEPTH)) bus ();

  fetch_unit #(
    .PC_W(PC_W), .START_PC(START_PC), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] next;
    logic            killed;
  } infl_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] pred;
    logic [1:0]      cause;
  } dec_t;

  typedef struct packed {
    logic [PC_W-1:0] addr;
    int              due;
    logic            fault;
  } mem_t;

  // reference model
  infl_t           infl_q[$];
  dec_t            exp_q[$];
  logic [PC_W-1:0] m_pc;
  bit              m_halt;

  // memory model and observation logs
  mem_t            mem_q[$];
  dec_t            deq_log[$];
  int              hs_log, first_hs_cyc, first_dv_cyc, max_fq;
  int              cyc;

  // stimulus knobs
  int              lat_min, lat_max, rdy_pct, req_rdy_pct, tk_pct, flt_pct;
  logic [PC_W-1:0] tk_pc, tk_tgt, flt_pc;

  int n_vec, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [PC_W-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ {a[47:32], 16'hC0DE};
  endfunction

  function automatic logic [PC_W-1:0] rand_pc();
    logic [PC_W-1:0] p;
    p = {16'h0000, 16'($urandom), 16'($urandom)};
    p[1:0] = ($urandom_range(15) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
    return p;
  endfunction

  function automatic dec_t log_at(input int i);
    dec_t z;
    z = '0;
    if (i < deq_log.size()) z = deq_log[i];
    return z;
  endfunction

  task automatic do_reset(input int n);
    reset                  = 1'b1;
    bus.redirect_valid     = 1'b0;
    bus.redirect_pc        = '0;
    bus.bp_taken           = 1'b0;
    bus.bp_target          = '0;
    bus.imem_req_ready     = 1'b1;
    bus.imem_rsp_valid     = 1'b0;
    bus.imem_rsp_data      = '0;
    bus.imem_rsp_fault     = 1'b0;
    bus.dec_ready          = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("rst_req_valid", bus.imem_req_valid, 0);
      check("rst_dec_valid", bus.dec_valid, 0);
      check("rst_fq_count", bus.fq_count, 0);
      @(posedge clk); #1; cyc++;
    end
    reset = 1'b0;
    exp_q.delete(); infl_q.delete(); mem_q.delete();
    m_pc = START_PC; m_halt = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model at the
  // falling edge, advance model and memory, then wait for the next edge.
  task automatic step(input bit redir, input logic [PC_W-1:0] rpc);
    logic            taken, rsp, exp_req, halt0;
    logic [PC_W-1:0] tgt, nxt;
    int              n0, i0, due;
    bit              hs;
    dec_t            e;
    infl_t           f;

    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (m_pc == tk_pc) begin
      taken = 1'b1; tgt = tk_tgt;
    end else begin
      taken = ($urandom_range(99) < tk_pct); tgt = rand_pc();
    end
    bus.bp_taken       = taken;
    bus.bp_target      = tgt;
    bus.dec_ready      = ($urandom_range(99) < rdy_pct);
    bus.imem_req_ready = ($urandom_range(99) < req_rdy_pct);
    rsp = 1'b0;
    bus.imem_rsp_data  = $urandom;
    bus.imem_rsp_fault = 1'b0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        rsp = 1'b1;
        bus.imem_rsp_data  = data_of(mem_q[0].addr);
        bus.imem_rsp_fault = mem_q[0].fault;
      end
    end
    bus.imem_rsp_valid = rsp;

    @(negedge clk);
    n0      = exp_q.size();
    i0      = infl_q.size();
    halt0   = m_halt;
    exp_req = !m_halt && (m_pc[1:0] == 2'b00) && (i0 < MAX_OUTST) &&
              ((n0 + i0) < FQ_DEPTH) && !redir;
    nxt     = taken ? tgt : m_pc + 48'd4;

    check("req_valid", bus.imem_req_valid, exp_req);
    if (!m_halt) check("bp_pc", bus.bp_pc, m_pc);
    if (exp_req) check("req_addr", bus.imem_req_addr, m_pc);
    check("fq_count", bus.fq_count, n0);
    check("dec_valid", bus.dec_valid, n0 != 0);
    if (n0 != 0) begin
      e = exp_q[0];
      check("dec_pc", bus.dec_pc, e.pc);
      check("dec_cause", bus.dec_trap_cause, e.cause);
      check("dec_instr", bus.dec_instr, e.instr);
      if (e.cause != 2'd1) begin
        check("dec_pred_taken", bus.dec_pred_taken, e.taken);
        check("dec_pred_pc", bus.dec_pred_pc, e.pred);
      end
    end

    hs = bus.imem_req_valid && bus.imem_req_ready;
    if (hs) hs_log++;
    if (hs && first_hs_cyc < 0) first_hs_cyc = cyc;
    if (bus.dec_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
    if (int'(bus.fq_count) > max_fq) max_fq = int'(bus.fq_count);
    if (bus.dec_valid && bus.dec_ready)
      deq_log.push_back('{instr: bus.dec_instr, pc: bus.dec_pc, taken: bus.dec_pred_taken,
                          pred: bus.dec_pred_pc, cause: bus.dec_trap_cause});

    if (redir) begin
      exp_q.delete();
      foreach (infl_q[k]) infl_q[k].killed = 1'b1;
      if (rsp && i0 > 0) void'(infl_q.pop_front());
      m_pc   = rpc;
      m_halt = 1'b0;
    end else begin
      if (n0 != 0 && bus.dec_ready) void'(exp_q.pop_front());
      if (rsp && i0 > 0) begin
        f = infl_q.pop_front();
        if (!f.killed && !halt0) begin
          exp_q.push_back('{instr: data_of(f.pc), pc: f.pc, taken: f.taken, pred: f.next,
                            cause: bus.imem_rsp_fault ? 2'd2 : 2'd0});
          if (bus.imem_rsp_fault) m_halt = 1'b1;
        end
      end
      if (!halt0 && m_pc[1:0] != 2'b00 && i0 == 0 && n0 < FQ_DEPTH) begin
        exp_q.push_back('{instr: 32'h0, pc: m_pc, taken: 1'b0, pred: '0, cause: 2'd1});
        m_halt = 1'b1;
      end
      if (exp_req && bus.imem_req_ready) begin
        infl_q.push_back('{pc: m_pc, taken: taken, next: nxt, killed: 1'b0});
        m_pc = nxt;
      end
    end

    if (rsp) void'(mem_q.pop_front());
    if (hs) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (mem_q.size() > 0) begin
        if (mem_q[$].due >= due) due = mem_q[$].due + 1;
      end
      mem_q.push_back('{addr: bus.imem_req_addr, due: due,
                        fault: (bus.imem_req_addr == flt_pc) || ($urandom_range(99) < flt_pct)});
    end

    @(posedge clk); #1; cyc++;
  endtask

  initial begin
    bit ok;
    n_vec = 0; n_err = 0; cyc = 0;
    lat_min = 1; lat_max = 1; rdy_pct = 100; req_rdy_pct = 100; tk_pct = 0; flt_pct = 0;
    tk_pc = NO_PC; tk_tgt = '0; flt_pc = NO_PC;
    hs_log = 0; first_hs_cyc = -1; first_dv_cyc = -1; max_fq = 0;

    // Sequential stream from START_PC, latency 1.
    do_reset(3);
    repeat (30) step(1'b0, '0);
    check("first_dec_latency", first_dv_cyc - first_hs_cyc, 2);
    check("seq_pc0", log_at(0).pc, 48'h1000);
    check("seq_pc1", log_at(1).pc, 48'h1004);
    check("seq_pc2", log_at(2).pc, 48'h1008);
    check("fq_max_le_depth", max_fq <= FQ_DEPTH, 1);

    // Decode stalls: queue fills to exactly FQ_DEPTH, then drains in order.
    rdy_pct = 0;
    repeat (20) step(1'b0, '0);
    check("stall_fq_full", bus.fq_count, FQ_DEPTH);
    rdy_pct = 100;
    deq_log.delete();
    repeat (12) step(1'b0, '0);
    for (int i = 1; i < 6; i++) check("drain_order", log_at(i).pc, log_at(i - 1).pc + 48'd4);

    // Taken prediction at 0x1008 steering to 0x2000.
    tk_pc = 48'h1008; tk_tgt = 48'h2000;
    step(1'b1, 48'h1000);
    deq_log.delete();
    repeat (15) step(1'b0, '0);
    check("bp_pc_1008", log_at(2).pc, 48'h1008);
    check("bp_taken_1008", log_at(2).taken, 1);
    check("bp_pred_1008", log_at(2).pred, 48'h2000);
    check("bp_after", log_at(3).pc, 48'h2000);
    tk_pc = NO_PC;

    // Latency 3, redirect while two requests are outstanding.
    lat_min = 3; lat_max = 3;
    step(1'b1, 48'h5000);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (infl_q.size() == 2) ok = 1'b1;
      else step(1'b0, '0);
    end
    check("two_outstanding", ok, 1);
    step(1'b1, 48'h3000);
    check("redir_fq_empty", bus.fq_count, 0);
    deq_log.delete();
    repeat (20) step(1'b0, '0);
    check("redir_resume", log_at(0).pc, 48'h3000);

    // Misaligned redirect target: single trap entry, no requests.
    lat_min = 1; lat_max = 1;
    hs_log = 0;
    step(1'b1, 48'h3002);
    deq_log.delete();
    repeat (20) step(1'b0, '0);
    check("mis_entries", deq_log.size(), 1);
    check("mis_pc", log_at(0).pc, 48'h3002);
    check("mis_cause", log_at(0).cause, 1);
    check("mis_no_req", hs_log, 0);
    step(1'b1, 48'h4000);
    deq_log.delete();
    repeat (10) step(1'b0, '0);
    check("mis_resume", log_at(0).pc, 48'h4000);

    // Access fault on 0x1004 with 0x1008 still in flight.
    lat_min = 2; lat_max = 2; flt_pc = 48'h1004;
    step(1'b1, 48'h1000);
    deq_log.delete();
    repeat (30) step(1'b0, '0);
    check("flt_entries", deq_log.size(), 2);
    check("flt_first_cause", log_at(0).cause, 0);
    check("flt_pc", log_at(1).pc, 48'h1004);
    check("flt_cause", log_at(1).cause, 2);
    flt_pc = NO_PC;

    // Randomized traffic with one mid-run reset.
    lat_min = 1; lat_max = 4; rdy_pct = 70; req_rdy_pct = 80; tk_pct = 15; flt_pct = 3;
    step(1'b1, START_PC);
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset(2);
      if (m_halt) step($urandom_range(99) < 15, rand_pc());
      else        step($urandom_range(99) < 3, rand_pc());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end.
- Generates the PC stream with branch-predictor steering and issues pipelined requests to instruction memory. Tolerates arbitrary in-order response latency.
- Buffers fetched instructions in a fetch queue ahead of decode, squashes in-flight work on redirect, and reports misaligned-PC and access-fault traps in program order.
- Sits between the branch predictor / instruction memory and the decode stage.

Parameters:
- PC_W, 48, PC and address width.
- START_PC, 0, PC loaded on reset.
- FQ_DEPTH, 4, fetch-queue entries; at least 2.
- MAX_OUTST, 2, maximum accepted-but-unanswered imem requests; at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  squash and restart from redirect_pc (execute mispredict or trap vector)
- redirect_pc  in  PC_W  restart PC
- bp_pc  out  PC_W  current fetch PC, presented to the predictor
- bp_taken  in  1  predictor says bp_pc is a taken control transfer (combinational)
- bp_target  in  PC_W  predicted target
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  request address, equal to bp_pc
- imem_rsp_valid  in  1  response valid; responses return in order, one per accepted request, latency of 1 cycle or more
- imem_rsp_data  in  32  instruction word
- imem_rsp_fault  in  1  access fault on this response
- dec_valid  out  1  fetch-queue head valid
- dec_ready  in  1  decode consumes head
- dec_instr  out  32  instruction
- dec_pc  out  PC_W  PC of instruction
- dec_pred_taken  out  1  prediction used
- dec_pred_pc  out  PC_W  predicted next PC
- dec_trap_cause  out  2  0 none, 1 misaligned PC, 2 access fault
- fq_count  out  $clog2(FQ_DEPTH+1)  current fetch-queue occupancy

Behaviour:
- Reset: fetch_pc = START_PC, state RUN, fetch queue and in-flight tag FIFO empty, outst = 0.
  - While reset is asserted: imem_req_valid = 0, dec_valid = 0, fq_count = 0.
- Request condition: imem_req_valid = state==RUN && fetch_pc[1:0]==0 && outst<MAX_OUTST && (fq_count+outst)<FQ_DEPTH && !redirect_valid.
  - The credit rule guarantees every response has a queue slot. No response is ever back-pressured.
- On request handshake:
  - Push {fetch_pc, bp_taken, next, kill=0} into the in-flight tag FIFO; outst++.
  - next = bp_taken ? bp_target : fetch_pc+4, wrapping modulo 2^PC_W; fetch_pc <= next.
- On imem_rsp_valid:
  - Pop the tag FIFO; outst--.
  - If the tag is not killed and state==RUN, enqueue {data, pc, pred, cause = fault ? 2 : 0}.
  - Push and pop in the same cycle leave outst unchanged.
- Latency: a response accepted in cycle t is visible at dec_valid in t+1. No bypass from imem to decode.
- Fetch queue: FIFO, registered outputs. Simultaneous enqueue and dequeue when full is legal because credit prevents overflow. Dequeue on dec_valid && dec_ready.
- Misaligned PC (fetch_pc[1:0] != 0, state RUN):
  - No imem request is issued.
  - Once outst==0 and the queue is not full, enqueue {instr 0, pc = fetch_pc, cause 1}, then go to HALT.
- Access fault: the faulting entry is enqueued and state goes to HALT. Later in-flight responses are popped and dropped.
- HALT: no requests, no enqueues. Decode drains the queue normally. Only redirect leaves HALT.
- redirect_valid (highest priority, any state):
  - Fetch queue cleared next cycle; every in-flight tag set kill=1.
  - fetch_pc <= redirect_pc; state <= RUN.
  - A response arriving in the same cycle is dropped.
  - imem_req_valid is forced to 0 that cycle. redirect_valid must not depend combinationally on imem_req_valid.
- Reset mid-operation: all state returns to reset values next cycle. Stale responses after reset are a memory-side protocol violation; outst must never underflow, so a response with outst==0 is ignored.
- Simultaneous dequeue and redirect: redirect wins; the queue ends empty.

Test Plan:
- Reset with START_PC=0x1000, memory latency 1, dec_ready=1, bp_taken=0 -> dec_pc sequence 0x1000, 0x1004, 0x1008, …; first dec_valid 2 cycles after the first handshake; fq_count never exceeds 4.
- dec_ready=0 for 20 cycles, MAX_OUTST=2 -> exactly FQ_DEPTH=4 entries enqueued; imem_req_valid low while fq_count+outst=4; no response lost; order preserved once dec_ready=1.
- bp_taken=1 at PC 0x1008 with bp_target=0x2000 -> dec_pc 0x1008 with dec_pred_taken=1 and dec_pred_pc=0x2000, followed by 0x2000.
- Latency 3, two requests outstanding, redirect_pc=0x3000 -> both stale responses dropped; queue empty; next dec_pc=0x3000.
- redirect to 0x3002 -> no imem request; one entry with cause 1 and pc 0x3002; then no further entries until redirect to 0x4000 resumes at 0x4000.
- imem_rsp_fault=1 on PC 0x1004, with 0x1008 in flight -> entry with cause 2 at 0x1004; the 0x1008 response is dropped; HALT until redirect.
